// File: rtl/cnn_score_collector.sv
// Collects one frame of CNN class scores, tracks a running argmax and replays
// the stored scores over a valid/ready dump channel after the result handshake.
module cnn_score_collector #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int LBL_W       = 5,
  parameter int ADDR_W      = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_start,
  input  logic              i_score_v,
  input  logic [ADDR_W-1:0] i_score_addr,
  input  logic [DATA_W-1:0] i_score_data,
  output logic              o_busy,
  output logic              o_res_v,
  input  logic              i_res_ready,
  output logic [LBL_W-1:0]  o_res_lbl,
  output logic [DATA_W-1:0] o_res_max,
  output logic              o_dump_v,
  input  logic              i_dump_ready,
  output logic [LBL_W-1:0]  o_dump_idx,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_frame_done,
  output logic              o_err_oor,
  output logic              o_err_dup
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;
  localparam logic [1:0] S_DUMP    = 2'd3;

  localparam int DEPTH = 1 << LBL_W;
  localparam int CNT_W = LBL_W + 1;
  localparam logic [LBL_W-1:0]  LAST_IDX = LBL_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_CLASSES - 1);
  localparam logic [ADDR_W-1:0] NUM_ADDR = ADDR_W'(NUM_CLASSES);

  logic [1:0]        state;
  logic [DEPTH-1:0]  mask;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] scores [DEPTH];

  logic [LBL_W-1:0]  slot;
  logic              in_range;
  logic              is_dup;
  logic              accept;
  logic              take_new;

  // The range check uses the full address so high bits can never alias a slot.
  assign slot     = i_score_addr[LBL_W-1:0];
  assign in_range = (i_score_addr < NUM_ADDR);
  assign is_dup   = in_range && mask[slot];
  assign accept   = (state == S_COLLECT) && i_score_v && in_range && !mask[slot];

  // o_res_max/o_res_lbl double as the running argmax; equal scores go to the lower index.
  assign take_new = (count == '0)
                 || ($signed(i_score_data) > $signed(o_res_max))
                 || ((i_score_data == o_res_max) && (slot < o_res_lbl));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      mask         <= '0;
      count        <= '0;
      o_busy       <= 1'b0;
      o_res_v      <= 1'b0;
      o_res_lbl    <= '0;
      o_res_max    <= '0;
      o_dump_v     <= 1'b0;
      o_dump_idx   <= '0;
      o_dump_data  <= '0;
      o_frame_done <= 1'b0;
      o_err_oor    <= 1'b0;
      o_err_dup    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        scores[i] <= '0;
      end
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state     <= S_COLLECT;
            o_busy    <= 1'b1;
            mask      <= '0;
            count     <= '0;
            o_res_lbl <= '0;
            o_res_max <= '0;
            o_err_oor <= 1'b0;
            o_err_dup <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (i_score_v && !in_range) o_err_oor <= 1'b1;
          if (i_score_v && is_dup)    o_err_dup <= 1'b1;
          if (accept) begin
            scores[slot] <= i_score_data;
            mask[slot]   <= 1'b1;
            count        <= count + 1'b1;
            if (take_new) begin
              o_res_lbl <= slot;
              o_res_max <= i_score_data;
            end
            if (count == LAST_CNT) begin
              state   <= S_RESULT;
              o_res_v <= 1'b1;
            end
          end
        end
        S_RESULT: begin
          if (i_res_ready) begin
            state       <= S_DUMP;
            o_res_v     <= 1'b0;
            o_dump_v    <= 1'b1;
            o_dump_idx  <= '0;
            o_dump_data <= scores[0];
          end
        end
        S_DUMP: begin
          if (i_dump_ready) begin
            if (o_dump_idx == LAST_IDX) begin
              state        <= S_IDLE;
              o_busy       <= 1'b0;
              o_dump_v     <= 1'b0;
              o_frame_done <= 1'b1;
            end else begin
              o_dump_idx  <= o_dump_idx + 1'b1;
              o_dump_data <= scores[o_dump_idx + 1'b1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_score_collector.sv
// Directed self-checking bench for cnn_score_collector with hand-computed expectations.
module tb_cnn_score_collector;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int AW = 32;

  logic          aclk;
  logic          aresetn;
  logic          i_start;
  logic          i_score_v;
  logic [AW-1:0] i_score_addr;
  logic [DW-1:0] i_score_data;
  logic          o_busy;
  logic          o_res_v;
  logic          i_res_ready;
  logic [LW-1:0] o_res_lbl;
  logic [DW-1:0] o_res_max;
  logic          o_dump_v;
  logic          i_dump_ready;
  logic [LW-1:0] o_dump_idx;
  logic [DW-1:0] o_dump_data;
  logic          o_frame_done;
  logic          o_err_oor;
  logic          o_err_dup;

  int tests_run  = 0;
  int fail_count = 0;
  int addr_q [16];
  int data_q [16];
  int exp_d  [NC];

  cnn_score_collector #(
    .NUM_CLASSES(NC), .DATA_W(DW), .LBL_W(LW), .ADDR_W(AW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .i_start(i_start),
    .i_score_v(i_score_v), .i_score_addr(i_score_addr), .i_score_data(i_score_data),
    .o_busy(o_busy), .o_res_v(o_res_v), .i_res_ready(i_res_ready),
    .o_res_lbl(o_res_lbl), .o_res_max(o_res_max),
    .o_dump_v(o_dump_v), .i_dump_ready(i_dump_ready),
    .o_dump_idx(o_dump_idx), .o_dump_data(o_dump_data),
    .o_frame_done(o_frame_done), .o_err_oor(o_err_oor), .o_err_dup(o_err_dup)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},       o_busy, 0);
    checkOutput({tag, "_res_v"},      o_res_v, 0);
    checkOutput({tag, "_dump_v"},     o_dump_v, 0);
    checkOutput({tag, "_frame_done"}, o_frame_done, 0);
    checkOutput({tag, "_err_oor"},    o_err_oor, 0);
    checkOutput({tag, "_err_dup"},    o_err_dup, 0);
    checkOutput({tag, "_res_lbl"},    o_res_lbl, 0);
    checkOutput({tag, "_res_max"},    o_res_max, 0);
    checkOutput({tag, "_dump_idx"},   o_dump_idx, 0);
    checkOutput({tag, "_dump_data"},  o_dump_data, 0);
  endtask

  task automatic loadFrameA;
    int vals [NC] = '{5, -3, 12, 7, 12, 0, -100, 4, 11, 2};
    for (int i = 0; i < NC; i++) begin
      addr_q[i] = i;
      data_q[i] = vals[i];
      exp_d[i]  = vals[i];
    end
  endtask

  task automatic startFrame;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    checkOutput("start_busy", o_busy, 1);
    checkOutput("start_err_oor_clear", o_err_oor, 0);
    checkOutput("start_err_dup_clear", o_err_dup, 0);
  endtask

  task automatic sendScores(input int n);
    for (int i = 0; i < n; i++) begin
      i_score_v    = 1'b1;
      i_score_addr = AW'(addr_q[i]);
      i_score_data = DW'(data_q[i]);
      tick;
      if (i == n - 2) checkOutput("res_v_early", o_res_v, 0);
    end
    i_score_v = 1'b0;
    checkOutput("res_v_latency", o_res_v, 1);
  endtask

  // Result handshake then dump; optional result stall, ready toggling,
  // ignored-input injection, or a reset once reset_at beats have completed.
  task automatic applyStimulus(input int exp_lbl, input int exp_max, input bit hold_res,
                               input bit toggle_dump, input bit inject, input int reset_at);
    int unstable = 0;
    int beats = 0;
    int idx_err = 0;
    int data_err = 0;
    int fd = 0;
    checkOutput("res_lbl", o_res_lbl, exp_lbl);
    checkOutput("res_max", $signed(o_res_max), exp_max);
    if (hold_res) begin
      i_res_ready = 1'b0;
      repeat (20) begin
        tick;
        if (o_res_v !== 1'b1 || o_res_lbl !== LW'(exp_lbl) || $signed(o_res_max) !== exp_max
            || o_dump_v !== 1'b0)
          unstable++;
      end
      checkOutput("res_hold_stable", unstable, 0);
    end
    i_res_ready = 1'b1;
    tick;
    i_res_ready = 1'b0;
    checkOutput("dump_enter_v", o_dump_v, 1);
    checkOutput("dump_enter_res_v", o_res_v, 0);
    for (int cyc = 0; cyc < 200 && beats < NC; cyc++) begin
      if (reset_at >= 0 && beats == reset_at) begin
        checkOutput("dump_idx_before_reset", o_dump_idx, reset_at);
        aresetn = 1'b0;
        #1;
        checkResetState("mid_dump");
        aresetn = 1'b1;
        repeat (3) begin
          tick;
          fd += int'(o_frame_done);
        end
        checkOutput("no_done_after_reset", fd, 0);
        return;
      end
      i_dump_ready = toggle_dump ? (cyc % 2 == 0) : 1'b1;
      i_start      = inject && (beats < NC - 1);
      i_score_v    = inject;
      i_score_addr = '0;
      i_score_data = DW'(999);
      if (!o_dump_v) idx_err++;
      else if (i_dump_ready) begin
        if (o_dump_idx !== LW'(beats)) idx_err++;
        if ($signed(o_dump_data) !== exp_d[beats]) data_err++;
        beats++;
      end
      tick;
      fd += int'(o_frame_done);
    end
    i_dump_ready = 1'b0;
    i_start      = 1'b0;
    i_score_v    = 1'b0;
    tick;
    fd += int'(o_frame_done);
    checkOutput("dump_beats", beats, NC);
    checkOutput("dump_idx_errors", idx_err, 0);
    checkOutput("dump_data_errors", data_err, 0);
    checkOutput("frame_done_pulses", fd, 1);
    checkOutput("end_busy", o_busy, 0);
    checkOutput("end_dump_v", o_dump_v, 0);
    checkOutput("end_res_lbl", o_res_lbl, exp_lbl);
    checkOutput("end_res_max", $signed(o_res_max), exp_max);
  endtask

  initial begin
    aresetn      = 1'b0;
    i_start      = 1'b0;
    i_score_v    = 1'b0;
    i_score_addr = '0;
    i_score_data = '0;
    i_res_ready  = 1'b1;
    i_dump_ready = 1'b1;
    #12;
    checkResetState("reset");
    aresetn = 1'b1;
    tick;

    // Basic frame, in-order indices, ties at 12 resolve to index 2.
    loadFrameA();
    startFrame();
    sendScores(NC);
    checkOutput("a_err_oor", o_err_oor, 0);
    checkOutput("a_err_dup", o_err_dup, 0);
    applyStimulus(2, 12, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("a_end_err_oor", o_err_oor, 0);
    checkOutput("a_end_err_dup", o_err_dup, 0);

    // Aliasing address, duplicate and out-of-range scores are all dropped.
    begin
      int a [13] = '{32'h10000, 0, 1, 2, 3, 3, 15, 4, 5, 6, 7, 8, 9};
      int d [13] = '{500, 1, 2, 3, 40, 99, 500, 5, 6, 7, 8, 9, 10};
      int e [NC] = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
      for (int i = 0; i < 13; i++) begin
        addr_q[i] = a[i];
        data_q[i] = d[i];
      end
      for (int i = 0; i < NC; i++) exp_d[i] = e[i];
    end
    startFrame();
    sendScores(13);
    checkOutput("b_err_oor", o_err_oor, 1);
    checkOutput("b_err_dup", o_err_dup, 1);
    applyStimulus(3, 40, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("b_sticky_err_oor", o_err_oor, 1);
    checkOutput("b_sticky_err_dup", o_err_dup, 1);

    // Reverse order, all equal; stalled result and toggling dump ready.
    for (int i = 0; i < NC; i++) begin
      addr_q[i] = NC - 1 - i;
      data_q[i] = -7;
      exp_d[i]  = -7;
    end
    startFrame();
    sendScores(NC);
    applyStimulus(0, -7, 1'b1, 1'b1, 1'b0, -1);

    // i_start and i_score_v driven throughout the dump must be ignored.
    loadFrameA();
    startFrame();
    sendScores(NC);
    applyStimulus(2, 12, 1'b0, 1'b0, 1'b1, -1);
    checkOutput("d_err_oor", o_err_oor, 0);
    checkOutput("d_err_dup", o_err_dup, 0);

    // Reset after five scores in COLLECT.
    startFrame();
    for (int i = 0; i < 5; i++) begin
      i_score_v    = 1'b1;
      i_score_addr = AW'(addr_q[i]);
      i_score_data = DW'(data_q[i]);
      tick;
    end
    i_score_v = 1'b0;
    aresetn = 1'b0;
    #1;
    checkResetState("mid_collect");
    aresetn = 1'b1;
    tick;
    checkOutput("after_reset_idle", o_busy, 0);

    // Reset in DUMP at k=4, then a clean frame.
    startFrame();
    sendScores(NC);
    applyStimulus(2, 12, 1'b0, 1'b0, 1'b0, 4);
    tick;
    startFrame();
    sendScores(NC);
    applyStimulus(2, 12, 1'b0, 1'b0, 1'b0, -1);
    checkOutput("f_err_oor", o_err_oor, 0);
    checkOutput("f_err_dup", o_err_dup, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/cnn_score_collector.md
CNN_SCORE_COLLECTOR -- requirements
Module: cnn_score_collector

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class scores per frame (2..32).
REQ-002 Parameter DATA_W, default 16, signed score width.
REQ-003 Parameter LBL_W, default 5, label/index width; SHALL satisfy 2**LBL_W >= NUM_CLASSES.
REQ-004 Parameter ADDR_W, default 32, score address width.
REQ-005 aclk  in  1  single clock; all logic on rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  one-cycle frame-start pulse.
REQ-008 i_score_v  in  1  score valid; no backpressure toward the source.
REQ-009 i_score_addr  in  ADDR_W  class index of the score.
REQ-010 i_score_data  in  DATA_W  signed class score.
REQ-011 o_busy  out  1  high in every state except IDLE.
REQ-012 o_res_v / i_res_ready / o_res_lbl[LBL_W] / o_res_max[DATA_W]  result channel: valid/ready, argmax label, max score.
REQ-013 o_dump_v / i_dump_ready / o_dump_idx[LBL_W] / o_dump_data[DATA_W]  score dump channel: valid/ready, index, score.
REQ-014 o_frame_done  out  1  one-cycle pulse at end of frame.
REQ-015 o_err_oor, o_err_dup  out  1 each  sticky errors: out-of-range address, duplicate address.

Function
REQ-016 FSM states IDLE, COLLECT, RESULT, DUMP; reset state IDLE.
REQ-017 IDLE -> COLLECT on i_start; in COLLECT, clear the received mask, count, running max and label, o_err_oor and o_err_dup.
REQ-018 i_start SHALL be ignored outside IDLE; i_score_v SHALL be ignored outside COLLECT.
REQ-019 In COLLECT, a score is accepted when i_score_v=1, addr < NUM_CLASSES and the mask bit for addr is clear; on acceptance: store data at addr, set mask bit, increment count.
REQ-020 addr >= NUM_CLASSES (full ADDR_W compare, no truncation): score dropped, o_err_oor set.
REQ-021 Duplicate addr (mask bit already set): score dropped, stored value unchanged, o_err_dup set.
REQ-022 Running argmax on each accepted score: take it if it is the first score, or data > max (signed), or data == max and addr < current label; ties resolve to the lowest index regardless of arrival order.
REQ-023 COLLECT -> RESULT in the cycle after the score that makes count == NUM_CLASSES is accepted; o_res_v SHALL be 1 in that next cycle (1-cycle latency).
REQ-024 In RESULT, o_res_v, o_res_lbl and o_res_max SHALL be held stable until i_res_ready=1; on the handshake go to DUMP with dump index 0.
REQ-025 In DUMP, o_dump_v=1 with o_dump_idx=k and o_dump_data=score[k]; hold until i_dump_ready; on the handshake, k increments; the handshake at k=NUM_CLASSES-1 goes to IDLE and pulses o_frame_done for one cycle.
REQ-026 The block SHALL NOT time out; it stays in COLLECT until all NUM_CLASSES distinct indices arrive.
REQ-027 Registered outputs only; no combinational path from i_res_ready or i_dump_ready to any output.

Reset
REQ-028 aresetn=0 SHALL asynchronously force IDLE; o_busy, o_res_v, o_dump_v, o_frame_done, o_err_oor, o_err_dup = 0; o_res_lbl, o_res_max, o_dump_idx, o_dump_data = 0; mask and count cleared.
REQ-029 Reset in any state SHALL abort the frame; no o_frame_done pulse is produced; the next frame requires a new i_start.
REQ-030 The error flags are cleared only by reset or by the next accepted i_start.

Verification
REQ-031 Stimulus: NUM_CLASSES=10, i_start, then scores addr 0..9 = {5,-3,12,7,12,0,-100,4,11,2}, both ready signals held at 1. Required: o_res_v 1 cycle after the last score, lbl=2, max=12; dump shows indices 0..9 with the same values; o_frame_done pulses once; both error flags = 0.
REQ-032 Stimulus: scores delivered in order 9..0, all equal to -7. Required: lbl=0, max=-7 (lowest-index tie-break).
REQ-033 Stimulus: frame containing addr 3 twice (40, then 99) plus addr 15 = 500, with the other indices < 40. Required: o_err_dup=1, o_err_oor=1, dump[3]=40, max=40, lbl=3, and RESULT is entered only after all 10 distinct indices are accepted.
REQ-034 Stimulus: i_res_ready held 0 for 20 cycles, then i_dump_ready toggled 1/0 every cycle. Required: result outputs stable while i_res_ready=0; dump index advances only on handshake cycles; 10 dump beats total.
REQ-035 Stimulus: aresetn pulsed low after 5 scores (in COLLECT), and again mid-DUMP at k=4. Required: all outputs = 0 immediately; no o_frame_done; a later frame behaves exactly as REQ-031.
REQ-036 Stimulus: i_start and i_score_v asserted while busy in DUMP. Required: both ignored; dump sequence and result unchanged.
